// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Ports: req0/req1 valid/ready + operands, alu_* to/from ALU, rsp_* registered result, op_count_o.
module alu_arbiter #(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_src1_i,
  input  logic [31:0] req0_src2_i,
  input  logic [4:0]  req0_ctrl_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_src1_i,
  input  logic [31:0] req1_src2_i,
  input  logic [4:0]  req1_ctrl_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [4:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_err_o,
  output logic [15:0] op_count_o
);

  localparam logic [4:0] LAST_LEGAL = 5'd18;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] op_count_q, op_count_d;
  logic        last_gnt_q, last_gnt_d;

  logic        slot_free;
  logic        gnt0;
  logic        gnt1;
  logic        gnt;
  logic [31:0] sel_src1;
  logic [31:0] sel_src2;
  logic [4:0]  sel_ctrl;
  logic        legal;
  logic        fwd;

  always_comb begin
    slot_free = !rsp_valid_q || rsp_ready_i;
    // req0 wins a contest under fixed priority or when req1 went last
    gnt0 = rst_i && slot_free && req0_valid_i &&
           (!req1_valid_i || (PRIO_FIXED != 0) || last_gnt_q);
    gnt1 = rst_i && slot_free && req1_valid_i && !gnt0;
    gnt  = gnt0 || gnt1;
    sel_src1 = gnt1 ? req1_src1_i : req0_src1_i;
    sel_src2 = gnt1 ? req1_src2_i : req0_src2_i;
    sel_ctrl = gnt1 ? req1_ctrl_i : req0_ctrl_i;
    legal = (sel_ctrl <= LAST_LEGAL);
    // illegal codes are consumed but never reach the ALU
    fwd = gnt && legal;
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign alu_src1_o   = fwd ? sel_src1 : 32'd0;
  assign alu_src2_o   = fwd ? sel_src2 : 32'd0;
  assign alu_ctrl_o   = fwd ? sel_ctrl : 5'd0;

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    last_gnt_d   = last_gnt_q;
    if (gnt) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt1;
      rsp_result_d = legal ? alu_result_i : 32'd0;
      rsp_zero_d   = legal ? alu_zero_i : 1'b0;
      rsp_err_d    = !legal;
      op_count_d   = op_count_q + 16'd1;
      last_gnt_d   = gnt1;
    end else if (rsp_ready_i) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= 16'd0;
      last_gnt_q   <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
      last_gnt_q   <= last_gnt_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_err_o    = rsp_err_q;
  assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter.
// Driver pushes expected responses; negedge monitor pops on handshake.
module tb_alu_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req0_valid_i = 1'b0;
  logic        req0_ready_o;
  logic [31:0] req0_src1_i = '0;
  logic [31:0] req0_src2_i = '0;
  logic [4:0]  req0_ctrl_i = '0;
  logic        req1_valid_i = 1'b0;
  logic        req1_ready_o;
  logic [31:0] req1_src1_i = '0;
  logic [31:0] req1_src2_i = '0;
  logic [4:0]  req1_ctrl_i = '0;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [4:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic        rsp_id_o;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o;
  logic        rsp_err_o;
  logic [15:0] op_count_o;

  alu_arbiter #(.PRIO_FIXED(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_src1_i(req0_src1_i), .req0_src2_i(req0_src2_i),
    .req0_ctrl_i(req0_ctrl_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_src1_i(req1_src1_i), .req1_src2_i(req1_src2_i),
    .req1_ctrl_i(req1_ctrl_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o),
    .rsp_zero_o(rsp_zero_o), .rsp_err_o(rsp_err_o),
    .op_count_o(op_count_o)
  );

  always #5 clk_i = ~clk_i;

  // tiny ALU: 2 = sub, everything else = add
  always_comb begin
    alu_result_i = (alu_ctrl_o == 5'd2) ? alu_src1_o - alu_src2_o
                                        : alu_src1_o + alu_src2_o;
    alu_zero_i = (alu_result_i == 32'd0);
  end

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b1;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (mon_en && rst_i && rsp_valid_o && rsp_ready_i) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=%0h required=none",
                 rsp_result_o);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", {31'd0, rsp_id_o}, {31'd0, e.id});
        chk("rsp_result", rsp_result_o, e.res);
        chk("rsp_zero", {31'd0, rsp_zero_o}, {31'd0, e.zero});
        chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic id, input logic [31:0] res,
                      input logic zero, input logic err);
    exp_t e;
    e.id = id;
    e.res = res;
    e.zero = zero;
    e.err = err;
    exp_q.push_back(e);
    exp_cnt++;
  endtask

  initial begin
    int n;
    #3;
    chk("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_count", {16'd0, op_count_o}, 32'd0);
    chk("rst_result", rsp_result_o, 32'd0);
    req0_valid_i = 1'b1;
    #1;
    chk("rst_ready0", {31'd0, req0_ready_o}, 32'd0);
    cyc();
    req0_valid_i = 1'b0;
    rst_i = 1'b1;
    rsp_ready_i = 1'b1;
    cyc();

    // single op from req0: 5-3
    req0_valid_i = 1'b1;
    req0_src1_i = 32'd5;
    req0_src2_i = 32'd3;
    req0_ctrl_i = 5'd2;
    #1;
    chk("single_ready0", {31'd0, req0_ready_o}, 32'd1);
    chk("single_alu_ctrl", {27'd0, alu_ctrl_o}, 32'd2);
    push(1'b0, 32'd2, 1'b0, 1'b0);
    cyc();
    req0_valid_i = 1'b0;
    chk("single_valid", {31'd0, rsp_valid_o}, 32'd1);

    // illegal code from req1
    req1_valid_i = 1'b1;
    req1_src1_i = 32'd9;
    req1_src2_i = 32'd9;
    req1_ctrl_i = 5'd25;
    #1;
    chk("ill_ready1", {31'd0, req1_ready_o}, 32'd1);
    chk("ill_alu_ctrl", {27'd0, alu_ctrl_o}, 32'd0);
    chk("ill_alu_src1", alu_src1_o, 32'd0);
    push(1'b1, 32'd0, 1'b0, 1'b1);
    cyc();
    req1_valid_i = 1'b0;
    chk("ill_err", {31'd0, rsp_err_o}, 32'd1);

    // contested: round robin 0,1,0,1
    req0_src1_i = 32'd10;
    req0_src2_i = 32'd4;
    req0_ctrl_i = 5'd0;
    req1_src1_i = 32'd7;
    req1_src2_i = 32'd7;
    req1_ctrl_i = 5'd2;
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", {31'd0, req0_ready_o}, {31'd0, k[0] == 1'b0});
      chk("rr_ready1", {31'd0, req1_ready_o}, {31'd0, k[0] == 1'b1});
      if (k[0] == 1'b0) push(1'b0, 32'd14, 1'b0, 1'b0);
      else push(1'b1, 32'd0, 1'b1, 1'b0);
      cyc();
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    chk("rr_count", {16'd0, op_count_o}, exp_cnt);
    cyc();

    // backpressure: hold, then drain plus new grant
    rsp_ready_i = 1'b0;
    req0_valid_i = 1'b1;
    req0_src1_i = 32'd1;
    req0_src2_i = 32'd2;
    req0_ctrl_i = 5'd0;
    push(1'b0, 32'd3, 1'b0, 1'b0);
    cyc();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b1;
    req1_src1_i = 32'd8;
    req1_src2_i = 32'd3;
    req1_ctrl_i = 5'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_ready0", {31'd0, req0_ready_o}, 32'd0);
      chk("hold_ready1", {31'd0, req1_ready_o}, 32'd0);
      chk("hold_result", rsp_result_o, 32'd3);
      chk("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
      cyc();
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("drain_ready1", {31'd0, req1_ready_o}, 32'd1);
    push(1'b1, 32'd5, 1'b0, 1'b0);
    cyc();
    req1_valid_i = 1'b0;
    chk("reload_valid", {31'd0, rsp_valid_o}, 32'd1);
    cyc();

    // reset with a pending response (req0 went last)
    rsp_ready_i = 1'b0;
    req0_valid_i = 1'b1;
    req0_src1_i = 32'd1;
    req0_src2_i = 32'd1;
    req0_ctrl_i = 5'd2;
    cyc();
    req0_valid_i = 1'b0;
    chk("pend_valid", {31'd0, rsp_valid_o}, 32'd1);
    #1;
    rst_i = 1'b0;
    req1_valid_i = 1'b1;
    #1;
    chk("arst_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("arst_ready1", {31'd0, req1_ready_o}, 32'd0);
    chk("arst_count", {16'd0, op_count_o}, 32'd0);
    exp_cnt = 0;
    cyc();
    rst_i = 1'b1;
    rsp_ready_i = 1'b1;
    req0_valid_i = 1'b1;
    req0_src1_i = 32'd6;
    req0_src2_i = 32'd6;
    req0_ctrl_i = 5'd0;
    req1_src1_i = 32'd1;
    req1_src2_i = 32'd1;
    req1_ctrl_i = 5'd0;
    #1;
    chk("post_rst_ready0", {31'd0, req0_ready_o}, 32'd1);
    chk("post_rst_ready1", {31'd0, req1_ready_o}, 32'd0);
    push(1'b0, 32'd12, 1'b0, 1'b0);
    cyc();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    cyc();

    // counter wrap
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk("sb_drained_pre", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    n = 65535 - exp_cnt;
    req0_valid_i = 1'b1;
    req0_ctrl_i = 5'd0;
    repeat (n) cyc();
    exp_cnt = 65535;
    req0_valid_i = 1'b0;
    #1;
    chk("count_ffff", {16'd0, op_count_o}, 32'h0000_FFFF);
    cyc();
    mon_en = 1'b1;
    req0_valid_i = 1'b1;
    req0_src1_i = 32'd2;
    req0_src2_i = 32'd2;
    push(1'b0, 32'd4, 1'b0, 1'b0);
    cyc();
    req0_valid_i = 1'b0;
    chk("count_wrap", {16'd0, op_count_o}, 32'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
